// File: rtl/alu_pipe_if.sv
// Request/response bundle for the two-stage pipelined ALU.
// The master drives requests and consumes results; the slave is the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       f;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, f, a, b, out_ready,
        input  in_ready, out_valid, y, zero, carry, overflow
    );

    modport slave (
        input  in_valid, f, a, b, out_ready,
        output in_ready, out_valid, y, zero, carry, overflow
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers the request, S2 registers the result and flags.
// S1 refills in the same edge it drains into S2, so a full pipe streams one op per cycle.
module alu_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ANDN = 4'b0100;
    localparam logic [3:0] OP_ORN  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic             s1_valid;
    logic [3:0]       s1_f;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_zero;
    logic             s2_carry;
    logic             s2_overflow;

    logic             advance;
    logic             in_ready;
    logic             accept;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic             sltu;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_y;
    logic             res_carry;
    logic             res_overflow;

    // Handshake: S2 frees when empty or drained; S1 frees when empty or moving into S2.
    always_comb begin
        advance  = !s2_valid || bus.out_ready;
        in_ready = !s1_valid || advance;
        accept   = bus.in_valid && in_ready;
    end

    // Result and flags from the operands held in S1.
    always_comb begin
        sum_ext      = {1'b0, s1_a} + {1'b0, s1_b};
        diff_ext     = {1'b0, s1_a} - {1'b0, s1_b};
        add_ovf      = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_ext[WIDTH-1] != s1_a[WIDTH-1]);
        sub_ovf      = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff_ext[WIDTH-1] != s1_a[WIDTH-1]);
        slt          = diff_ext[WIDTH-1] ^ sub_ovf;
        sltu         = diff_ext[WIDTH];
        shamt        = s1_b[SHW-1:0];
        res_y        = '0;
        res_carry    = 1'b0;
        res_overflow = 1'b0;
        case (s1_f)
            OP_AND:  res_y = s1_a & s1_b;
            OP_OR:   res_y = s1_a | s1_b;
            OP_ADD: begin
                res_y        = sum_ext[WIDTH-1:0];
                res_carry    = sum_ext[WIDTH];
                res_overflow = add_ovf;
            end
            OP_XOR:  res_y = s1_a ^ s1_b;
            OP_ANDN: res_y = s1_a & ~s1_b;
            OP_ORN:  res_y = s1_a | ~s1_b;
            OP_SUB: begin
                res_y        = diff_ext[WIDTH-1:0];
                res_carry    = ~diff_ext[WIDTH];
                res_overflow = sub_ovf;
            end
            OP_SLT:  res_y = {{(WIDTH-1){1'b0}}, slt};
            OP_SLL:  res_y = s1_a << shamt;
            OP_SRL:  res_y = s1_a >> shamt;
            OP_SRA:  res_y = $unsigned($signed(s1_a) >>> shamt);
            OP_SLTU: res_y = {{(WIDTH-1){1'b0}}, sltu};
            OP_NOR:  res_y = ~(s1_a | s1_b);
            default: res_y = '0;
        endcase
    end

    // Valid bits and the visible result registers; result reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s2_y        <= '0;
            s2_zero     <= 1'b0;
            s2_carry    <= 1'b0;
            s2_overflow <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_y        <= res_y;
                    s2_zero     <= (res_y == '0);
                    s2_carry    <= res_carry;
                    s2_overflow <= res_overflow;
                end
            end
        end
    end

    // Request operands; no reset needed, qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_f <= bus.f;
            s1_a <= bus.a;
            s1_b <= bus.b;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.y         = s2_y;
    assign bus.zero      = s2_zero;
    assign bus.carry     = s2_carry;
    assign bus.overflow  = s2_overflow;
endmodule
